multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MULT_CYCLES, default 5: execution cycles held in MDU state for mult.
REQ-002 Parameter DIV_CYCLES, default 10: execution cycles held in MDU state for div; both SHALL be >=1.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 opcode  in  6  IR[31:26]; stable from DECODE until instruction end.
REQ-006 funct  in  6  IR[5:0]; stable likewise.
REQ-007 PCWrite  out  1  unconditional PC update this cycle.
REQ-008 IRWrite  out  1  latch fetched word into IR.
REQ-009 Beq, Bgtz  out  1 each  conditional PC update; datapath gates with its comparator.
REQ-010 MemRead, MemWrite, RegWrite  out  1 each  memory/register-file strobes.
REQ-011 ALUControl  out  3  000 add, 001 sub, 010 xor, 011 or, 100 sll.
REQ-012 ALUSrc  out  1; RegDst  out  2 (00 rt, 01 rd, 10 $31); EXTControl  out  3 (000 zero, 001 sign, 010 lui).
REQ-013 Mem2Reg  out  3  000 ALU, 001 word, 010 lui, 011 PC+4, 100 byte, 101 HI, 110 LO.
REQ-014 NPCControl  out  3  000 PC+4, 001 branch, 010 j/jal, 100 jr/jalr.
REQ-015 md_start  out  1  one-cycle pulse launching mult/div; md_op out 1 (0 mult, 1 div).
REQ-016 md_busy  out  1  high throughout MDU state.
REQ-017 instr_done  out  1  high in the final cycle of every instruction.
REQ-018 state  out  3  current FSM state, for debug.

Function
REQ-019 States: FETCH, DECODE, EXE, MEM, WB, MDU; encodings per package.
REQ-020 FETCH: MemRead=1, IRWrite=1, PCWrite=1, NPCControl=000; next DECODE.
REQ-021 DECODE: all strobes 0; next per instruction class below.
REQ-022 add/sub/xor/sll/ori/addi/lui/mfhi/mflo: DECODE->EXE->WB->FETCH (4 cycles); RegWrite only in WB.
REQ-023 lw/lb: DECODE->EXE->MEM->WB (5 cycles); MemRead in MEM; RegWrite, Mem2Reg 001/100 in WB.
REQ-024 sw: DECODE->EXE->MEM (4 cycles); MemWrite=1 only in MEM.
REQ-025 beq/bgtz/j/jr: DECODE->EXE (3 cycles); EXE asserts Beq/Bgtz or PCWrite with matching NPCControl.
REQ-026 jal/jalr: DECODE->EXE (3 cycles); EXE asserts PCWrite, RegWrite, Mem2Reg=011, RegDst 10/01.
REQ-027 mult/div: DECODE->MDU; md_start=1 on first MDU cycle only; stay MDU for exactly MULT_CYCLES/DIV_CYCLES cycles, then FETCH.
REQ-028 MDU down-counter loads N-1 on DECODE exit, decrements each MDU cycle, exits at 0; width clog2(max(MULT_CYCLES,DIV_CYCLES))+1.
REQ-029 Undefined opcode/funct: DECODE->FETCH, no strobe asserted, instr_done=1 in DECODE.
REQ-030 Datapath-select outputs (ALUControl, ALUSrc, RegDst, EXTControl, Mem2Reg) SHALL hold decoded values from DECODE to instruction end; strobes assert only in listed states.
REQ-031 instr_done asserts in WB, MEM (sw), EXE (branch/jump), last MDU cycle, or DECODE (undefined); exactly once per instruction.

Reset
REQ-032 reset=1 at a clock edge SHALL force state=FETCH and MDU counter=0, overriding any state including mid-MDU.
REQ-033 During reset-asserted cycles all strobes, md_start, md_busy, instr_done SHALL be 0; first post-reset cycle is FETCH.

Structure
REQ-034 Package mc_ctrl_pkg SHALL hold state enum, opcode/funct constants, ALUControl/Mem2Reg/NPCControl/EXTControl codes.
REQ-035 Combinational decode (instruction class plus select outputs) SHALL live in sub-module mc_decode; FSM and counter in top.

Verification
REQ-036 reset then add $3,$1,$2 -> states FETCH,DECODE,EXE,WB; RegWrite=1, RegDst=01 only in cycle 4; instr_done cycle 4.
REQ-037 lw then sw -> lw 5 cycles, MemRead in cycle 4, RegWrite cycle 5; sw 4 cycles, MemWrite one cycle only.
REQ-038 mult with MULT_CYCLES=5, then div with DIV_CYCLES=10 -> md_busy high 5 then 10 cycles; md_start one pulse each; md_op 0 then 1.
REQ-039 reset asserted in 3rd MDU cycle of div -> next cycle FETCH, md_busy=0, no instr_done.
REQ-040 opcode 6'b111111 -> FETCH,DECODE,FETCH; no strobes; instr_done in DECODE.
REQ-041 jal then jr -> 3 cycles each; jal EXE: PCWrite=1, RegWrite=1, RegDst=10, NPCControl=010; jr EXE: NPCControl=100, RegWrite=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction classes,
// opcode/funct values and the datapath select codes driven to the datapath.
package mc_ctrl_pkg;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXE    = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_MDU    = 3'd5;

    typedef enum logic [2:0] {
        CLS_UNDEF, CLS_ALU, CLS_LOAD, CLS_STORE,
        CLS_BRANCH, CLS_JUMP, CLS_JLINK, CLS_MD
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_XOR   = 6'b100110;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [2:0] EXT_ZERO = 3'b000;
    localparam logic [2:0] EXT_SIGN = 3'b001;
    localparam logic [2:0] EXT_LUI  = 3'b010;

    localparam logic [2:0] M2R_ALU  = 3'b000;
    localparam logic [2:0] M2R_WORD = 3'b001;
    localparam logic [2:0] M2R_LUI  = 3'b010;
    localparam logic [2:0] M2R_PC4  = 3'b011;
    localparam logic [2:0] M2R_BYTE = 3'b100;
    localparam logic [2:0] M2R_HI   = 3'b101;
    localparam logic [2:0] M2R_LO   = 3'b110;

    localparam logic [2:0] NPC_PC4  = 3'b000;
    localparam logic [2:0] NPC_BR   = 3'b001;
    localparam logic [2:0] NPC_JUMP = 3'b010;
    localparam logic [2:0] NPC_JR   = 3'b100;

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction-field inputs and control outputs between controller (master) and datapath (slave).
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       PCWrite, IRWrite, Beq, Bgtz;
  logic       MemRead, MemWrite, RegWrite;
  logic [2:0] ALUControl;
  logic       ALUSrc;
  logic [1:0] RegDst;
  logic [2:0] EXTControl, Mem2Reg, NPCControl;
  logic       md_start, md_op, md_busy, instr_done;
  logic [2:0] state;

  modport master (
    input  opcode, funct,
    output PCWrite, IRWrite, Beq, Bgtz, MemRead, MemWrite, RegWrite,
           ALUControl, ALUSrc, RegDst, EXTControl, Mem2Reg, NPCControl,
           md_start, md_op, md_busy, instr_done, state
  );

  modport slave (
    output opcode, funct,
    input  PCWrite, IRWrite, Beq, Bgtz, MemRead, MemWrite, RegWrite,
           ALUControl, ALUSrc, RegDst, EXTControl, Mem2Reg, NPCControl,
           md_start, md_op, md_busy, instr_done, state
  );
endinterface

// File: rtl/mc_decode.sv
// Pure combinational instruction decode: class for the FSM plus datapath select codes.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic [2:0]   alu_ctrl,
  output logic         alu_src,
  output logic [1:0]   reg_dst,
  output logic [2:0]   ext_ctrl,
  output logic [2:0]   mem2reg,
  output logic [2:0]   npc_ctrl,
  output logic         md_div,
  output logic         br_gt
);
  always_comb begin
    cls      = CLS_UNDEF;
    alu_ctrl = ALU_ADD;
    alu_src  = 1'b0;
    reg_dst  = RD_RT;
    ext_ctrl = EXT_ZERO;
    mem2reg  = M2R_ALU;
    npc_ctrl = NPC_PC4;
    md_div   = 1'b0;
    br_gt    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_dst = RD_RD;
        case (funct)
          FN_ADD:  cls = CLS_ALU;
          FN_SUB:  begin cls = CLS_ALU; alu_ctrl = ALU_SUB; end
          FN_XOR:  begin cls = CLS_ALU; alu_ctrl = ALU_XOR; end
          FN_SLL:  begin cls = CLS_ALU; alu_ctrl = ALU_SLL; end
          FN_MFHI: begin cls = CLS_ALU; mem2reg = M2R_HI; end
          FN_MFLO: begin cls = CLS_ALU; mem2reg = M2R_LO; end
          FN_JR:   begin cls = CLS_JUMP; npc_ctrl = NPC_JR; end
          FN_JALR: begin cls = CLS_JLINK; npc_ctrl = NPC_JR; mem2reg = M2R_PC4; end
          FN_MULT: cls = CLS_MD;
          FN_DIV:  begin cls = CLS_MD; md_div = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI: begin cls = CLS_ALU; alu_src = 1'b1; ext_ctrl = EXT_SIGN; end
      OP_ORI:  begin cls = CLS_ALU; alu_src = 1'b1; alu_ctrl = ALU_OR; end
      OP_LUI:  begin cls = CLS_ALU; alu_src = 1'b1; ext_ctrl = EXT_LUI; mem2reg = M2R_LUI; end
      OP_LW:   begin cls = CLS_LOAD; alu_src = 1'b1; ext_ctrl = EXT_SIGN; mem2reg = M2R_WORD; end
      OP_LB:   begin cls = CLS_LOAD; alu_src = 1'b1; ext_ctrl = EXT_SIGN; mem2reg = M2R_BYTE; end
      OP_SW:   begin cls = CLS_STORE; alu_src = 1'b1; ext_ctrl = EXT_SIGN; end
      OP_BEQ:  begin cls = CLS_BRANCH; alu_ctrl = ALU_SUB; ext_ctrl = EXT_SIGN; npc_ctrl = NPC_BR; end
      OP_BGTZ: begin cls = CLS_BRANCH; ext_ctrl = EXT_SIGN; npc_ctrl = NPC_BR; br_gt = 1'b1; end
      OP_J:    begin cls = CLS_JUMP; npc_ctrl = NPC_JUMP; end
      OP_JAL:  begin cls = CLS_JLINK; npc_ctrl = NPC_JUMP; reg_dst = RD_RA; mem2reg = M2R_PC4; end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM with a down-counter timing mult/div in the MDU state.
// Strobes are decoded from the current state; reset forces them low in the same cycle.
module multicycle_controller #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  multicycle_controller_if.master bus
);
  import mc_ctrl_pkg::*;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  logic [2:0]    st, nxt;
  logic [CW-1:0] cnt, load_val;

  instr_class_t cls;
  logic [2:0] alu_ctrl, ext_ctrl, mem2reg, npc_ctrl;
  logic [1:0] reg_dst;
  logic       alu_src, md_div, br_gt;

  mc_decode u_decode (
    .opcode   (bus.opcode),
    .funct    (bus.funct),
    .cls      (cls),
    .alu_ctrl (alu_ctrl),
    .alu_src  (alu_src),
    .reg_dst  (reg_dst),
    .ext_ctrl (ext_ctrl),
    .mem2reg  (mem2reg),
    .npc_ctrl (npc_ctrl),
    .md_div   (md_div),
    .br_gt    (br_gt)
  );

  assign load_val = md_div ? DIV_LOAD : MULT_LOAD;

  always_comb begin
    nxt = S_FETCH;
    case (st)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = (cls == CLS_UNDEF) ? S_FETCH : (cls == CLS_MD) ? S_MDU : S_EXE;
      S_EXE:    nxt = (cls == CLS_ALU) ? S_WB :
                      (cls == CLS_LOAD || cls == CLS_STORE) ? S_MEM : S_FETCH;
      S_MEM:    nxt = (cls == CLS_LOAD) ? S_WB : S_FETCH;
      S_WB:     nxt = S_FETCH;
      S_MDU:    nxt = (cnt == '0) ? S_FETCH : S_MDU;
      default:  nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= S_FETCH;
      cnt <= '0;
    end else begin
      st <= nxt;
      if (st == S_DECODE && cls == CLS_MD)
        cnt <= load_val;
      else if (st == S_MDU && cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

  logic pc_wr, ir_wr, beq_s, bgtz_s, mem_rd, mem_wr, reg_wr, md_go, busy, done;

  always_comb begin
    pc_wr = 1'b0; ir_wr = 1'b0; beq_s = 1'b0; bgtz_s = 1'b0;
    mem_rd = 1'b0; mem_wr = 1'b0; reg_wr = 1'b0;
    md_go = 1'b0; busy = 1'b0; done = 1'b0;
    if (!reset) begin
      case (st)
        S_FETCH:  begin mem_rd = 1'b1; ir_wr = 1'b1; pc_wr = 1'b1; end
        S_DECODE: done = (cls == CLS_UNDEF);
        S_EXE: begin
          beq_s  = (cls == CLS_BRANCH) && !br_gt;
          bgtz_s = (cls == CLS_BRANCH) && br_gt;
          pc_wr  = (cls == CLS_JUMP) || (cls == CLS_JLINK);
          reg_wr = (cls == CLS_JLINK);
          done   = (cls == CLS_BRANCH) || (cls == CLS_JUMP) || (cls == CLS_JLINK);
        end
        S_MEM: begin
          mem_rd = (cls == CLS_LOAD);
          mem_wr = (cls == CLS_STORE);
          done   = (cls == CLS_STORE);
        end
        S_WB:  begin reg_wr = 1'b1; done = 1'b1; end
        S_MDU: begin
          busy  = 1'b1;
          md_go = (cnt == load_val);
          done  = (cnt == '0);
        end
        default: ;
      endcase
    end
  end

  // Selects follow the decoded IR from DECODE on; during FETCH the IR is changing.
  logic sel_en;
  assign sel_en = (st != S_FETCH);

  assign bus.PCWrite    = pc_wr;
  assign bus.IRWrite    = ir_wr;
  assign bus.Beq        = beq_s;
  assign bus.Bgtz       = bgtz_s;
  assign bus.MemRead    = mem_rd;
  assign bus.MemWrite   = mem_wr;
  assign bus.RegWrite   = reg_wr;
  assign bus.md_start   = md_go;
  assign bus.md_busy    = busy;
  assign bus.instr_done = done;
  assign bus.md_op      = md_div;
  assign bus.state      = st;
  assign bus.ALUControl = sel_en ? alu_ctrl : ALU_ADD;
  assign bus.ALUSrc     = sel_en ? alu_src  : 1'b0;
  assign bus.RegDst     = sel_en ? reg_dst  : RD_RT;
  assign bus.EXTControl = sel_en ? ext_ctrl : EXT_ZERO;
  assign bus.Mem2Reg    = sel_en ? mem2reg  : M2R_ALU;
  assign bus.NPCControl = sel_en ? npc_ctrl : NPC_PC4;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed cycle-by-cycle bench for multicycle_controller with MULT_CYCLES=5, DIV_CYCLES=10.
module tb_multicycle_controller;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // strobe vector bit positions: {PCWrite,IRWrite,Beq,Bgtz,MemRead,MemWrite,RegWrite,md_start,md_busy,instr_done}
  localparam logic [9:0] PCW  = 10'h200;
  localparam logic [9:0] IRW  = 10'h100;
  localparam logic [9:0] BEQ  = 10'h080;
  localparam logic [9:0] MR   = 10'h020;
  localparam logic [9:0] MW   = 10'h010;
  localparam logic [9:0] RW   = 10'h008;
  localparam logic [9:0] MDS  = 10'h004;
  localparam logic [9:0] MDB  = 10'h002;
  localparam logic [9:0] DONE = 10'h001;
  localparam logic [9:0] FET  = PCW | IRW | MR;

  function automatic logic [9:0] strb();
    return {bus.PCWrite, bus.IRWrite, bus.Beq, bus.Bgtz, bus.MemRead, bus.MemWrite,
            bus.RegWrite, bus.md_start, bus.md_busy, bus.instr_done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [2:0] st, input logic [9:0] s);
    chk({tag, ".state"}, {29'd0, bus.state}, {29'd0, st});
    chk({tag, ".strobes"}, {22'd0, strb()}, {22'd0, s});
  endtask

  task automatic cyc(input string tag, input logic [2:0] st, input logic [9:0] s);
    @(posedge clk);
    #1;
    look(tag, st, s);
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode = op;
    bus.funct  = fn;
  endtask

  initial begin
    reset = 1'b1;
    set_ir(OP_RTYPE, FN_ADD);
    @(posedge clk); #1;
    @(posedge clk); #1;
    look("reset", S_FETCH, 10'h000);
    reset = 1'b0;
    #1;
    look("add.fetch", S_FETCH, FET);
    chk("add.fetch.npc", {29'd0, bus.NPCControl}, {29'd0, NPC_PC4});

    cyc("add.decode", S_DECODE, 10'h000);
    chk("add.decode.alu", {29'd0, bus.ALUControl}, 32'h0);
    cyc("add.exe", S_EXE, 10'h000);
    cyc("add.wb", S_WB, RW | DONE);
    chk("add.wb.regdst", {30'd0, bus.RegDst}, 32'h1);
    chk("add.wb.m2r", {29'd0, bus.Mem2Reg}, 32'h0);

    cyc("lw.fetch", S_FETCH, FET);
    set_ir(OP_LW, 6'd0);
    cyc("lw.decode", S_DECODE, 10'h000);
    cyc("lw.exe", S_EXE, 10'h000);
    chk("lw.exe.alusrc", {31'd0, bus.ALUSrc}, 32'h1);
    chk("lw.exe.ext", {29'd0, bus.EXTControl}, 32'h1);
    cyc("lw.mem", S_MEM, MR);
    cyc("lw.wb", S_WB, RW | DONE);
    chk("lw.wb.m2r", {29'd0, bus.Mem2Reg}, 32'h1);
    chk("lw.wb.regdst", {30'd0, bus.RegDst}, 32'h0);

    cyc("sw.fetch", S_FETCH, FET);
    set_ir(OP_SW, 6'd0);
    cyc("sw.decode", S_DECODE, 10'h000);
    cyc("sw.exe", S_EXE, 10'h000);
    cyc("sw.mem", S_MEM, MW | DONE);

    cyc("mult.fetch", S_FETCH, FET);
    set_ir(OP_RTYPE, FN_MULT);
    cyc("mult.decode", S_DECODE, 10'h000);
    for (int i = 0; i < 5; i++) begin
      cyc($sformatf("mult.mdu%0d", i), S_MDU,
          MDB | ((i == 0) ? MDS : 10'h0) | ((i == 4) ? DONE : 10'h0));
      if (i == 0) chk("mult.mdop", {31'd0, bus.md_op}, 32'h0);
    end

    cyc("div.fetch", S_FETCH, FET);
    set_ir(OP_RTYPE, FN_DIV);
    cyc("div.decode", S_DECODE, 10'h000);
    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("div.mdu%0d", i), S_MDU,
          MDB | ((i == 0) ? MDS : 10'h0) | ((i == 9) ? DONE : 10'h0));
      if (i == 0) chk("div.mdop", {31'd0, bus.md_op}, 32'h1);
    end

    cyc("divrst.fetch", S_FETCH, FET);
    cyc("divrst.decode", S_DECODE, 10'h000);
    cyc("divrst.mdu0", S_MDU, MDB | MDS);
    cyc("divrst.mdu1", S_MDU, MDB);
    cyc("divrst.mdu2", S_MDU, MDB);
    reset = 1'b1;
    #1;
    look("divrst.inreset", S_MDU, 10'h000);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    look("divrst.after", S_FETCH, FET);

    set_ir(6'b111111, 6'd0);
    cyc("undef.decode", S_DECODE, DONE);
    cyc("undef.fetch", S_FETCH, FET);

    set_ir(OP_JAL, 6'd0);
    cyc("jal.decode", S_DECODE, 10'h000);
    cyc("jal.exe", S_EXE, PCW | RW | DONE);
    chk("jal.regdst", {30'd0, bus.RegDst}, 32'h2);
    chk("jal.npc", {29'd0, bus.NPCControl}, 32'h2);
    chk("jal.m2r", {29'd0, bus.Mem2Reg}, 32'h3);

    cyc("jr.fetch", S_FETCH, FET);
    set_ir(OP_RTYPE, FN_JR);
    cyc("jr.decode", S_DECODE, 10'h000);
    cyc("jr.exe", S_EXE, PCW | DONE);
    chk("jr.npc", {29'd0, bus.NPCControl}, 32'h4);

    cyc("beq.fetch", S_FETCH, FET);
    set_ir(OP_BEQ, 6'd0);
    cyc("beq.decode", S_DECODE, 10'h000);
    cyc("beq.exe", S_EXE, BEQ | DONE);
    chk("beq.npc", {29'd0, bus.NPCControl}, 32'h1);
    cyc("end.fetch", S_FETCH, FET);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
